// File: rtl/arbiter_wrr_if.sv
`default_nettype none
// ============================================================================
//  Module   : arbiter_wrr_if
//  Purpose  : Request/grant bundle between contending masters and the
//             weighted round-robin arbiter.
//  Revision : 1.0 - initial release
// ============================================================================
interface arbiter_wrr_if #(
  parameter int NUM_PORTS = 6,
  parameter int WEIGHT_W  = 4
);
  localparam int IDX_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

  logic [NUM_PORTS-1:0]          request;
  logic [NUM_PORTS-1:0]          lock;
  logic [NUM_PORTS*WEIGHT_W-1:0] weight;
  logic [NUM_PORTS-1:0]          grant;
  logic [IDX_W-1:0]              grant_idx;
  logic                          active;

  // Requesters drive request/lock/weight and observe the grant.
  modport master (
    output request, lock, weight,
    input  grant, grant_idx, active
  );

  // The arbiter consumes requests and produces the grant.
  modport slave (
    input  request, lock, weight,
    output grant, grant_idx, active
  );
endinterface
`default_nettype wire

// File: rtl/arbiter_wrr.sv
`default_nettype none
// ============================================================================
//  Module   : arbiter_wrr
//  Purpose  : Weighted round-robin arbiter. Each winner owns the resource for
//             max(weight,1) consecutive cycles; an owner asserting lock holds
//             the grant indefinitely with its remaining quantum frozen.
//  Revision : 1.0 - initial release
// ============================================================================
module arbiter_wrr #(
  parameter int NUM_PORTS = 6,
  parameter int WEIGHT_W  = 4
) (
  input  wire logic      clk,
  input  wire logic      rst,
  arbiter_wrr_if.slave   bus
);
  localparam int IDX_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

  logic [NUM_PORTS-1:0] grant_q, grant_d;
  logic [IDX_W-1:0]     grant_idx_q, grant_idx_d;
  logic                 active_q, active_d;
  logic [WEIGHT_W-1:0]  credit_q, credit_d;
  logic [IDX_W-1:0]     last_owner_q, last_owner_d;

  logic                 keep;
  logic                 found;
  logic [IDX_W-1:0]     win;
  logic [WEIGHT_W-1:0]  win_weight;
  int                   cand;

  // Next-state: either the owner keeps the grant, or a round-robin search
  // starting just after the last owner picks the next requester. The last
  // owner sits at the end of the scan so it only wins when alone.
  always_comb begin
    grant_d      = grant_q;
    grant_idx_d  = grant_idx_q;
    active_d     = active_q;
    credit_d     = credit_q;
    last_owner_d = last_owner_q;
    found        = 1'b0;
    win          = '0;
    cand         = 0;

    keep = active_q & bus.request[grant_idx_q] &
           (bus.lock[grant_idx_q] | (credit_q > WEIGHT_W'(1)));

    for (int off = 1; off <= NUM_PORTS; off++) begin
      cand = int'(last_owner_q) + off;
      if (cand >= NUM_PORTS) cand = cand - NUM_PORTS;
      if (!found && bus.request[cand]) begin
        found = 1'b1;
        win   = IDX_W'(cand);
      end
    end

    win_weight = bus.weight[int'(win)*WEIGHT_W +: WEIGHT_W];

    if (keep) begin
      // A locked owner freezes its quantum; otherwise count it down.
      if (!bus.lock[grant_idx_q]) credit_d = credit_q - WEIGHT_W'(1);
    end else if (found) begin
      grant_d      = '0;
      grant_d[win] = 1'b1;
      grant_idx_d  = win;
      active_d     = 1'b1;
      last_owner_d = win;
      credit_d     = (win_weight == '0) ? WEIGHT_W'(1) : win_weight;
    end else begin
      // Nobody asking: go idle but remember who was last served.
      grant_d  = '0;
      active_d = 1'b0;
    end
  end

  // State register; reset points last_owner at the top port so port 0 leads.
  always_ff @(posedge clk) begin
    if (rst) begin
      grant_q      <= '0;
      grant_idx_q  <= '0;
      active_q     <= 1'b0;
      credit_q     <= '0;
      last_owner_q <= IDX_W'(NUM_PORTS - 1);
    end else begin
      grant_q      <= grant_d;
      grant_idx_q  <= grant_idx_d;
      active_q     <= active_d;
      credit_q     <= credit_d;
      last_owner_q <= last_owner_d;
    end
  end

  assign bus.grant     = grant_q;
  assign bus.grant_idx = grant_idx_q;
  assign bus.active    = active_q;
endmodule
`default_nettype wire
